memoria_iniciador: RTL and testbench

Command-driven initiator for the two-bank, two-port register memory (`memoria_DMULC`). Accepts single commands over a valid/ready handshake and sequences the memory's port strobes, addresses and data: write, read, bank fill and bank-to-bank copy. Returns one response per command. Sits between the control FSM and the memory, replacing hand-driven `w1/w2/r1/r2` sequencing.

---
 rtl/memoria_iniciador.sv | 195 +++++++++++++++++++
 tb/tb_memoria_iniciador.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memoria_iniciador.sv
// Command-driven initiator for the two-bank, two-port register memory.
// Sequences write, read, fill and bank-to-bank copy and returns one response per command.
module memoria_iniciador #(
    parameter int AW    = 4,
    parameter int DW    = 8,
    parameter int DEPTH = 15
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [1:0]    cmd_op,
    input  logic          cmd_port,
    input  logic [AW-1:0] cmd_addr,
    input  logic [DW-1:0] cmd_data,
    output logic          rsp_valid,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic [AW-1:0] ADD1,
    output logic [AW-1:0] ADD2,
    output logic [DW-1:0] DAT1,
    output logic [DW-1:0] DAT2,
    output logic          w1,
    output logic          w2,
    output logic          r1,
    output logic          r2,
    input  logic [DW-1:0] Dato1,
    input  logic [DW-1:0] Dato2
);

    typedef enum logic [2:0] {IDLE, WR, RD, RD_WAIT, FILL, COPY, RSP} state_t;

    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
    localparam logic [AW:0]   DEPTH_W = (AW + 1)'(DEPTH);

    state_t               state_reg;
    logic                 port_reg;
    logic [DW-1:0]        data_reg;
    logic [AW-1:0]        k_reg;
    logic [1:0]           w_reg;
    logic [1:0]           r_reg;
    logic [1:0]           byp_reg;
    logic [1:0][AW-1:0]   add_reg;
    logic [1:0][DW-1:0]   dat_reg;
    logic                 rsp_valid_reg;
    logic                 rsp_err_reg;
    logic [DW-1:0]        rsp_data_reg;

    logic [1:0][DW-1:0]   dato;
    logic [1:0][DW-1:0]   dat_out;
    logic                 addr_ok;

    assign addr_ok   = ({1'b0, cmd_addr} < DEPTH_W);
    assign cmd_ready = (state_reg == IDLE);
    assign dato[0]   = Dato1;
    assign dato[1]   = Dato2;

    // During copy the source read data only arrives in the same cycle as the
    // destination write, so the write data is forwarded straight from Dato.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            assign dat_out[gi] = byp_reg[gi] ? dato[1 - gi] : dat_reg[gi];
        end
    endgenerate

    assign ADD1      = add_reg[0];
    assign ADD2      = add_reg[1];
    assign DAT1      = dat_out[0];
    assign DAT2      = dat_out[1];
    assign w1        = w_reg[0];
    assign w2        = w_reg[1];
    assign r1        = r_reg[0];
    assign r2        = r_reg[1];
    assign rsp_valid = rsp_valid_reg;
    assign rsp_err   = rsp_err_reg;
    assign rsp_data  = rsp_data_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            port_reg      <= 1'b0;
            data_reg      <= '0;
            k_reg         <= '0;
            w_reg         <= '0;
            r_reg         <= '0;
            byp_reg       <= '0;
            add_reg       <= '0;
            dat_reg       <= '0;
            rsp_valid_reg <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_data_reg  <= '0;
        end else begin
            // Strobes, addresses and data fall back to zero unless a state drives them.
            w_reg         <= '0;
            r_reg         <= '0;
            byp_reg       <= '0;
            add_reg       <= '0;
            dat_reg       <= '0;
            rsp_valid_reg <= 1'b0;

            case (state_reg)
                IDLE: begin
                    if (cmd_valid) begin
                        port_reg <= cmd_port;
                        data_reg <= cmd_data;
                        k_reg    <= '0;
                        case (cmd_op)
                            2'b00: begin
                                if (addr_ok) begin
                                    w_reg[cmd_port]   <= 1'b1;
                                    add_reg[cmd_port] <= cmd_addr;
                                    dat_reg[cmd_port] <= cmd_data;
                                    state_reg         <= WR;
                                end else begin
                                    rsp_err_reg   <= 1'b1;
                                    rsp_valid_reg <= 1'b1;
                                    state_reg     <= RSP;
                                end
                            end
                            2'b01: begin
                                if (addr_ok) begin
                                    r_reg[cmd_port]   <= 1'b1;
                                    add_reg[cmd_port] <= cmd_addr;
                                    state_reg         <= RD;
                                end else begin
                                    rsp_err_reg   <= 1'b1;
                                    rsp_valid_reg <= 1'b1;
                                    state_reg     <= RSP;
                                end
                            end
                            2'b10: begin
                                w_reg[cmd_port]   <= 1'b1;
                                dat_reg[cmd_port] <= cmd_data;
                                state_reg         <= FILL;
                            end
                            default: begin
                                r_reg[cmd_port] <= 1'b1;
                                state_reg       <= COPY;
                            end
                        endcase
                    end
                end
                WR: begin
                    rsp_valid_reg <= 1'b1;
                    state_reg     <= RSP;
                end
                RD: begin
                    state_reg <= RD_WAIT;
                end
                RD_WAIT: begin
                    rsp_data_reg  <= dato[port_reg];
                    rsp_valid_reg <= 1'b1;
                    state_reg     <= RSP;
                end
                FILL: begin
                    if (k_reg == LAST) begin
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= RSP;
                    end else begin
                        k_reg             <= k_reg + AW'(1);
                        w_reg[port_reg]   <= 1'b1;
                        add_reg[port_reg] <= k_reg + AW'(1);
                        dat_reg[port_reg] <= data_reg;
                    end
                end
                COPY: begin
                    // A high source read marks the read phase; its absence is the trailing write.
                    if (r_reg[port_reg]) begin
                        w_reg[~port_reg]   <= 1'b1;
                        byp_reg[~port_reg] <= 1'b1;
                        add_reg[~port_reg] <= k_reg;
                        if (k_reg != LAST) begin
                            r_reg[port_reg]   <= 1'b1;
                            add_reg[port_reg] <= k_reg + AW'(1);
                            k_reg             <= k_reg + AW'(1);
                        end
                    end else begin
                        rsp_valid_reg <= 1'b1;
                        state_reg     <= RSP;
                    end
                end
                RSP: begin
                    rsp_err_reg  <= 1'b0;
                    rsp_data_reg <= '0;
                    state_reg    <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memoria_iniciador.sv
// Bench for memoria_iniciador with a two-bank memory model and a response scoreboard.
module tb_memoria_iniciador;

    typedef struct packed {
        logic       err;
        logic [7:0] data;
    } rsp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [1:0] cmd_op = '0;
    logic       cmd_port = 1'b0;
    logic [3:0] cmd_addr = '0;
    logic [7:0] cmd_data = '0;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       rsp_err;
    logic [3:0] ADD1, ADD2;
    logic [7:0] DAT1, DAT2;
    logic       w1, w2, r1, r2;
    logic [7:0] Dato1 = '0;
    logic [7:0] Dato2 = '0;

    logic [7:0] bank [2][16] = '{default: '0};
    logic [7:0] ref_mem [2][16];
    rsp_t       exp_q [$];

    logic [3:0] strb_hist [0:63];
    logic [3:0] add1_hist [0:63];
    logic [3:0] add2_hist [0:63];
    logic [7:0] dat1_hist [0:63];

    int checks = 0;
    int errors = 0;
    int rsp_total = 0;

    memoria_iniciador #(.AW(4), .DW(8), .DEPTH(15)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_port(cmd_port), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .ADD1(ADD1), .ADD2(ADD2), .DAT1(DAT1), .DAT2(DAT2),
        .w1(w1), .w2(w2), .r1(r1), .r2(r2),
        .Dato1(Dato1), .Dato2(Dato2)
    );

    always #5 clk = ~clk;

    // Memory: synchronous write, registered read.
    always @(posedge clk) begin
        if (w1) bank[0][ADD1] <= DAT1;
        if (r1) Dato1 <= bank[0][ADD1];
        if (w2) bank[1][ADD2] <= DAT2;
        if (r2) Dato2 <= bank[1][ADD2];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Strobe rules checked every cycle outside reset.
    always @(negedge clk) begin
        if (reset) begin
            check("w1_r1_exclusive", 32'(w1 & r1), 32'(0));
            check("w2_r2_exclusive", 32'(w2 & r2), 32'(0));
            if (!(w1 || r1)) check("add1_idle_zero", 32'(ADD1), 32'(0));
            if (!(w2 || r2)) check("add2_idle_zero", 32'(ADD2), 32'(0));
            if (!w1) check("dat1_idle_zero", 32'(DAT1), 32'(0));
            if (!w2) check("dat2_idle_zero", 32'(DAT2), 32'(0));
        end
    end

    // Scoreboard: pop one expectation per response pulse.
    always @(negedge clk) begin
        if (reset && rsp_valid) begin
            rsp_total++;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_rsp: observed rsp_valid=1 expected no response pending");
            end
            if (exp_q.size() != 0) begin
                rsp_t e;
                e = exp_q.pop_front();
                check("rsp_err", 32'(rsp_err), 32'(e.err));
                check("rsp_data", 32'(rsp_data), 32'(e.data));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed simulation still running expected finish");
        $fatal(1);
    end

    task automatic drive(input logic [1:0] op, input logic port, input logic [3:0] addr, input logic [7:0] data);
        cmd_op = op;
        cmd_port = port;
        cmd_addr = addr;
        cmd_data = data;
        cmd_valid = 1'b1;
    endtask

    task automatic scramble();
        cmd_op = 2'($urandom);
        cmd_port = 1'($urandom);
        cmd_addr = 4'($urandom);
        cmd_data = 8'($urandom);
    endtask

    // Present a command at a falling edge and return just after the accepting rising edge.
    task automatic send(input logic [1:0] op, input logic port, input logic [3:0] addr, input logic [7:0] data);
        int waited;
        @(negedge clk);
        drive(op, port, addr, data);
        waited = 0;
        while (!cmd_ready && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        assert (cmd_ready) else begin
            errors++;
            $error("FAIL ready_timeout: observed cmd_ready=0 expected 1 within 100 cycles");
        end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        scramble();
    endtask

    task automatic push_expect(input logic [1:0] op, input logic port, input logic [3:0] addr, input logic [7:0] data);
        rsp_t e;
        e.err = (op[1] == 1'b0) && (addr >= 4'd15);
        e.data = (op == 2'b01 && !e.err) ? ref_mem[port][addr] : 8'h00;
        exp_q.push_back(e);
        case (op)
            2'b00: if (!e.err) ref_mem[port][addr] = data;
            2'b10: for (int i = 0; i < 15; i++) ref_mem[port][i] = data;
            2'b11: for (int i = 0; i < 15; i++) ref_mem[~port][i] = ref_mem[port][i];
            default: ;
        endcase
    endtask

    // Run one command; lat is the cycle (relative to acceptance) carrying rsp_valid.
    task automatic run_cmd(input logic [1:0] op, input logic port, input logic [3:0] addr,
                           input logic [7:0] data, output int lat);
        push_expect(op, port, addr, data);
        send(op, port, addr, data);
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            strb_hist[n] = {r2, w2, r1, w1};
            add1_hist[n] = ADD1;
            add2_hist[n] = ADD2;
            dat1_hist[n] = DAT1;
            if (rsp_valid) begin
                lat = n;
                break;
            end
        end
        checks++;
        assert (lat != 0) else begin
            errors++;
            $error("FAIL rsp_timeout: observed no rsp_valid expected one within 40 cycles");
        end
    endtask

    initial begin
        int lat;
        int n;
        int nrsp;
        int first_n;
        int second_n;

        for (int p = 0; p < 2; p++)
            for (int a = 0; a < 16; a++)
                ref_mem[p][a] = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        check("reset_cmd_ready", 32'(cmd_ready), 32'(1));
        check("reset_strobes", 32'({r2, w2, r1, w1}), 32'(0));
        check("reset_rsp_valid", 32'(rsp_valid), 32'(0));
        check("reset_add_dat", 32'({ADD1, ADD2, DAT1, DAT2}), 32'(0));
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Write then read, port 1
        run_cmd(2'b00, 1'b0, 4'd3, 8'hA5, lat);
        check("wr_latency", 32'(lat), 32'(2));
        check("wr_strobe_t1", 32'(strb_hist[1]), 32'(4'b0001));
        check("wr_add1_t1", 32'(add1_hist[1]), 32'(3));
        check("wr_dat1_t1", 32'(dat1_hist[1]), 32'(8'hA5));
        check("wr_strobe_t2", 32'(strb_hist[2]), 32'(0));
        run_cmd(2'b01, 1'b0, 4'd3, 8'h00, lat);
        check("rd_latency", 32'(lat), 32'(3));
        check("rd_strobe_t1", 32'(strb_hist[1]), 32'(4'b0010));
        check("rd_add1_t1", 32'(add1_hist[1]), 32'(3));
        check("rd_strobe_t2", 32'(strb_hist[2]), 32'(0));
        @(negedge clk);
        check("ready_after_rsp", 32'(cmd_ready), 32'(1));

        // Fill bank 2, copy to bank 1
        run_cmd(2'b10, 1'b1, 4'd0, 8'd52, lat);
        check("fill_latency", 32'(lat), 32'(16));
        check("fill_strobe_t1", 32'(strb_hist[1]), 32'(4'b0100));
        check("fill_strobe_t15", 32'(strb_hist[15]), 32'(4'b0100));
        check("fill_add2_t15", 32'(add2_hist[15]), 32'(14));
        check("fill_strobe_t16", 32'(strb_hist[16]), 32'(0));
        run_cmd(2'b11, 1'b1, 4'd0, 8'h00, lat);
        check("copy_latency", 32'(lat), 32'(17));
        check("copy_strobe_t1", 32'(strb_hist[1]), 32'(4'b1000));
        check("copy_add2_t1", 32'(add2_hist[1]), 32'(0));
        check("copy_strobe_t2", 32'(strb_hist[2]), 32'(4'b1001));
        check("copy_add2_t2", 32'(add2_hist[2]), 32'(1));
        check("copy_add1_t2", 32'(add1_hist[2]), 32'(0));
        check("copy_dat1_t2", 32'(dat1_hist[2]), 32'(52));
        check("copy_strobe_t15", 32'(strb_hist[15]), 32'(4'b1001));
        check("copy_strobe_t16", 32'(strb_hist[16]), 32'(4'b0001));
        check("copy_add1_t16", 32'(add1_hist[16]), 32'(14));
        check("copy_strobe_t17", 32'(strb_hist[17]), 32'(0));
        for (int a = 0; a < 15; a++) begin
            run_cmd(2'b01, 1'b0, 4'(a), 8'h00, lat);
            run_cmd(2'b01, 1'b1, 4'(a), 8'h00, lat);
        end

        // Copy with distinct data: bank 1 = address, then copy to bank 2
        for (int a = 0; a < 15; a++) run_cmd(2'b00, 1'b0, 4'(a), 8'(a), lat);
        run_cmd(2'b11, 1'b0, 4'd0, 8'h00, lat);
        check("copy2_latency", 32'(lat), 32'(17));
        check("copy2_strobe_t2", 32'(strb_hist[2]), 32'(4'b0110));
        for (int a = 0; a < 15; a++) run_cmd(2'b01, 1'b1, 4'(a), 8'h00, lat);

        // Address errors
        run_cmd(2'b01, 1'b0, 4'd15, 8'h00, lat);
        check("rd_err_latency", 32'(lat), 32'(1));
        check("rd_err_strobes", 32'(strb_hist[1]), 32'(0));
        run_cmd(2'b00, 1'b1, 4'd15, 8'hFF, lat);
        check("wr_err_latency", 32'(lat), 32'(1));
        check("wr_err_strobes", 32'(strb_hist[1]), 32'(0));
        run_cmd(2'b01, 1'b1, 4'd14, 8'h00, lat);
        run_cmd(2'b01, 1'b0, 4'd14, 8'h00, lat);

        // Handshake hold: second fill held valid while the first runs
        push_expect(2'b10, 1'b0, 4'd0, 8'h3C);
        push_expect(2'b10, 1'b0, 4'd0, 8'h77);
        @(negedge clk);
        drive(2'b10, 1'b0, 4'd0, 8'h3C);
        @(posedge clk);
        #1;
        cmd_data = 8'h77;
        n = 0;
        nrsp = 0;
        first_n = 0;
        second_n = 0;
        while (n < 60 && nrsp < 2) begin
            @(negedge clk);
            n++;
            if (rsp_valid) begin
                nrsp++;
                if (nrsp == 1) first_n = n;
                else begin
                    second_n = n;
                    cmd_valid = 1'b0;
                end
            end
        end
        cmd_valid = 1'b0;
        check("hold_first_rsp", 32'(first_n), 32'(16));
        check("hold_second_rsp", 32'(second_n), 32'(33));
        repeat (20) @(negedge clk);
        run_cmd(2'b01, 1'b0, 4'd0, 8'h00, lat);
        run_cmd(2'b01, 1'b0, 4'd14, 8'h00, lat);

        // Reset in the middle of a fill of bank 2
        send(2'b10, 1'b1, 4'd0, 8'h99);
        repeat (7) @(negedge clk);
        check("abort_strobe_t7", 32'({r2, w2, r1, w1}), 32'(4'b0100));
        check("abort_add2_t7", 32'(ADD2), 32'(6));
        #1;
        reset = 1'b0;
        #1;
        check("abort_strobes_async", 32'({r2, w2, r1, w1}), 32'(0));
        check("abort_add_dat_async", 32'({ADD2, DAT2}), 32'(0));
        check("abort_ready_async", 32'(cmd_ready), 32'(1));
        repeat (2) @(negedge clk);
        reset = 1'b1;
        for (int a = 0; a < 6; a++) ref_mem[1][a] = 8'h99;
        repeat (3) @(negedge clk);
        check("abort_ready_after", 32'(cmd_ready), 32'(1));
        run_cmd(2'b01, 1'b1, 4'd5, 8'h00, lat);
        check("post_reset_rd_latency", 32'(lat), 32'(3));
        run_cmd(2'b01, 1'b1, 4'd6, 8'h00, lat);

        repeat (3) @(negedge clk);
        check("pending_rsp", 32'(exp_q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
